// File: rtl/run_controller.sv
// Run/dump sequencer: holds the core in reset, counts run cycles under a watchdog,
// then reads a memory window over req/ack and streams it out on valid/ready.
module run_controller #(
    parameter int unsigned       ADDR_W       = 16,
    parameter int unsigned       DATA_W       = 32,
    parameter int unsigned       CORE_RST_LEN = 2,
    parameter int unsigned       TIMEOUT      = 1000,
    parameter logic [ADDR_W-1:0] DUMP_BASE    = 16'h8000,
    parameter int unsigned       DUMP_WORDS   = 64
) (
    input  logic              clk,
    input  logic              rst,
    output logic              core_rst,
    input  logic              halt,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    output logic              done,
    output logic              timed_out,
    output logic [31:0]       cycle_count
);

    localparam int unsigned IDX_W  = (DUMP_WORDS == 0) ? 1 : $clog2(DUMP_WORDS + 1);
    localparam int unsigned RCNT_W = (CORE_RST_LEN < 2) ? 1 : $clog2(CORE_RST_LEN);
    localparam int unsigned STEP   = DATA_W / 8;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'((DUMP_WORDS == 0) ? 0 : DUMP_WORDS - 1);
    localparam logic [RCNT_W-1:0] RST_LAST = RCNT_W'(CORE_RST_LEN - 1);
    localparam logic [31:0]       TO_LAST  = 32'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] STEP_A   = ADDR_W'(STEP);

    typedef enum logic [2:0] {
        ST_CORE_RST,
        ST_RUN,
        ST_DUMP_REQ,
        ST_DUMP_OUT,
        ST_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [RCNT_W-1:0] rcnt;
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] word_addr;
    logic              at_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_CORE_RST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        core_rst   = 1'b0;
        mem_req    = 1'b0;
        dump_valid = 1'b0;
        done       = 1'b0;
        unique case (state)
            ST_CORE_RST: begin
                core_rst = 1'b1;
                if (rcnt == RST_LAST) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (halt || cycle_count == TO_LAST)
                    state_nxt = (DUMP_WORDS == 0) ? ST_DONE : ST_DUMP_REQ;
            end
            ST_DUMP_REQ: begin
                mem_req = 1'b1;
                if (mem_ack) state_nxt = ST_DUMP_OUT;
            end
            ST_DUMP_OUT: begin
                dump_valid = 1'b1;
                if (dump_ready) state_nxt = at_last ? ST_DONE : ST_DUMP_REQ;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                state_nxt = ST_CORE_RST;
            end
        endcase
    end

    // Address arithmetic is ADDR_W wide so the window wraps modulo 2^ADDR_W.
    always_comb begin
        word_addr = DUMP_BASE + ADDR_W'(idx) * STEP_A;
        at_last   = (idx == LAST_IDX);
        mem_addr  = mem_req ? word_addr : '0;
        dump_last = dump_valid && at_last;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rcnt        <= '0;
            idx         <= '0;
            cycle_count <= '0;
            timed_out   <= 1'b0;
            dump_addr   <= '0;
            dump_data   <= '0;
        end else begin
            if (state == ST_CORE_RST && rcnt != RST_LAST) rcnt <= rcnt + 1'b1;
            // halt takes priority: a same-cycle halt freezes the count without flagging timeout
            if (state == ST_RUN && !halt) begin
                if (cycle_count == TO_LAST) timed_out <= 1'b1;
                else if (cycle_count != '1) cycle_count <= cycle_count + 32'd1;
            end
            if (state == ST_DUMP_REQ && mem_ack) begin
                dump_data <= mem_rdata;
                dump_addr <= word_addr;
            end
            if (state == ST_DUMP_OUT && dump_ready && !at_last) idx <= idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_run_controller.sv
// Randomized bench for run_controller: three configurations run side by side against
// a handshake-level reference model, plus literal checks of key results per run.
module tb_run_controller;

    localparam int ND      = 3;
    localparam int AW      = 16;
    localparam int DW      = 32;
    localparam int NEVER   = -1;
    localparam int RANDH   = -2;
    localparam int NOABORT = -1;
    localparam int MAXRUNS = 6;
    localparam int LIM     = 60000;

    localparam int P_LEN   [ND] = '{2, 2, 3};
    localparam int P_TO    [ND] = '{1000, 20, 10};
    localparam int P_BASE  [ND] = '{32'h8000, 32'hFFF8, 32'h1234};
    localparam int P_WORDS [ND] = '{64, 4, 0};

    typedef struct {
        int h;
        bit rnd;
        int abort;
    } run_t;

    logic          clk;
    logic          rst        [ND];
    logic          halt       [ND];
    logic          mem_ack    [ND];
    logic          dump_ready [ND];
    logic [DW-1:0] mem_rdata  [ND];
    logic          core_rst   [ND];
    logic          mem_req    [ND];
    logic          dump_valid [ND];
    logic          dump_last  [ND];
    logic          done       [ND];
    logic          timed_out  [ND];
    logic [AW-1:0] mem_addr   [ND];
    logic [AW-1:0] dump_addr  [ND];
    logic [DW-1:0] dump_data  [ND];
    logic [31:0]   cycle_count[ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        run_controller #(
            .ADDR_W      (AW),
            .DATA_W      (DW),
            .CORE_RST_LEN(P_LEN[g]),
            .TIMEOUT     (P_TO[g]),
            .DUMP_BASE   (16'(P_BASE[g])),
            .DUMP_WORDS  (P_WORDS[g])
        ) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .core_rst   (core_rst[g]),
            .halt       (halt[g]),
            .mem_req    (mem_req[g]),
            .mem_addr   (mem_addr[g]),
            .mem_ack    (mem_ack[g]),
            .mem_rdata  (mem_rdata[g]),
            .dump_valid (dump_valid[g]),
            .dump_ready (dump_ready[g]),
            .dump_addr  (dump_addr[g]),
            .dump_data  (dump_data[g]),
            .dump_last  (dump_last[g]),
            .done       (done[g]),
            .timed_out  (timed_out[g]),
            .cycle_count(cycle_count[g])
        );
    end

    run_t        plan [ND][MAXRUNS];
    int          nruns[ND];
    int          rlow [ND], k[ND], hh[ND], ee[ND], widx[ND], mph[ND], stl[ND];
    int          run_i[ND], dcyc[ND], nwords[ND];
    bit          texp [ND], fin[ND], seen_req[ND];
    logic [15:0] first_addr[ND], last_addr[ND];
    logic [31:0] last_data [ND];
    logic [15:0] cap [ND][8];
    int          ncmp, nerr, cyc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s dut%0d run%0d t=%0t: got %0h want %0h", nm, d, run_i[d], $time, act, exp);
        end
    endtask

    // Memory contents: the word at BASE+4i holds i.
    function automatic logic [31:0] mem_word(input int d, input logic [15:0] a);
        return 32'(((int'(a) - P_BASE[d]) & 32'hFFFF) >> 2);
    endfunction

    function automatic logic [15:0] exp_addr(input int d, input int i);
        return 16'(P_BASE[d] + 4 * i);
    endfunction

    function automatic int pick(input int d, input bit is_ack);
        if (plan[d][run_i[d]].rnd) return $urandom_range(0, 5);
        return is_ack ? 1 : 0;
    endfunction

    task automatic noise(input int d);
        halt[d]       = 1'($urandom_range(0, 1));
        mem_ack[d]    = 1'($urandom_range(0, 1));
        dump_ready[d] = 1'($urandom_range(0, 1));
        mem_rdata[d]  = $urandom;
    endtask

    task automatic chk_reset(input int d);
        chk("rst_core_rst", d, 32'(core_rst[d]), 32'd1);
        chk("rst_flags", d, 32'({mem_req[d], dump_valid[d], dump_last[d], done[d], timed_out[d]}), 32'd0);
        chk("rst_mem_addr", d, 32'(mem_addr[d]), 32'd0);
        chk("rst_dump_addr", d, 32'(dump_addr[d]), 32'd0);
        chk("rst_dump_data", d, dump_data[d], 32'd0);
        chk("rst_cycle_count", d, cycle_count[d], 32'd0);
    endtask

    task automatic start_run(input int d);
        int h;
        h = plan[d][run_i[d]].h;
        if (h == RANDH) h = $urandom_range(0, 200);
        hh[d] = h;
        if (h >= 0 && h < P_TO[d]) begin
            ee[d] = h;
            texp[d] = 1'b0;
        end else begin
            ee[d] = P_TO[d] - 1;
            texp[d] = 1'b1;
        end
        k[d]        = 0;
        widx[d]     = 0;
        mph[d]      = (P_WORDS[d] == 0) ? 2 : 0;
        stl[d]      = pick(d, 1'b1);
        dcyc[d]     = 0;
        nwords[d]   = 0;
        seen_req[d] = 1'b0;
    endtask

    task automatic begin_reset(input int d);
        rst[d] = 1'b0;
        rlow[d] = 5;
        run_i[d]++;
        #1;
        chk_reset(d);
    endtask

    task automatic end_checks(input int d);
        logic [15:0] wa [4];
        wa = '{16'hFFF8, 16'hFFFC, 16'h0000, 16'h0004};
        if (d == 0 && run_i[d] == 0) begin
            chk("t2_cycles", d, cycle_count[d], 32'd37);
            chk("t2_timed_out", d, 32'(timed_out[d]), 32'd0);
            chk("t2_nwords", d, 32'(nwords[d]), 32'd64);
            chk("t2_first_addr", d, 32'(first_addr[d]), 32'h8000);
            chk("t2_last_addr", d, 32'(last_addr[d]), 32'h80FC);
            chk("t2_last_data", d, last_data[d], 32'd63);
        end
        if (d == 0 && run_i[d] == 1) begin
            chk("t3_cycles", d, cycle_count[d], 32'd999);
            chk("t3_timed_out", d, 32'(timed_out[d]), 32'd1);
        end
        if (d == 0 && run_i[d] == 2) begin
            chk("t3_tie_cycles", d, cycle_count[d], 32'd999);
            chk("t3_tie_timed_out", d, 32'(timed_out[d]), 32'd0);
        end
        if (d == 1 && run_i[d] == 0) begin
            for (int i = 0; i < 4; i++) chk("t5_wrap_addr", d, 32'(cap[d][i]), 32'(wa[i]));
        end
        if (d == 2 && run_i[d] == 0) begin
            chk("t5_zero_cycles", d, cycle_count[d], 32'd4);
            chk("t5_zero_no_req", d, 32'(seen_req[d]), 32'd0);
        end
        if (d == 2 && run_i[d] == 1) begin
            chk("t5_zero_to_cycles", d, cycle_count[d], 32'd9);
            chk("t5_zero_timed_out", d, 32'(timed_out[d]), 32'd1);
        end
    endtask

    task automatic step(input int d);
        int post;
        if (fin[d]) begin
            halt[d] = 1'b0;
            mem_ack[d] = 1'b0;
            dump_ready[d] = 1'b0;
            return;
        end
        if (rlow[d] > 0) begin
            chk_reset(d);
            rlow[d]--;
            noise(d);
            if (rlow[d] == 0) begin
                rst[d] = 1'b1;
                start_run(d);
            end
            return;
        end
        k[d]++;
        post = P_LEN[d] + ee[d] + 1;
        chk("core_rst", d, 32'(core_rst[d]), 32'(k[d] < P_LEN[d]));
        if (mem_req[d]) seen_req[d] = 1'b1;
        noise(d);
        if (k[d] < post) begin
            chk("cycle_count_run", d, cycle_count[d], 32'((k[d] < P_LEN[d]) ? 0 : k[d] - P_LEN[d]));
            chk("idle_run", d, 32'({mem_req[d], dump_valid[d], dump_last[d], done[d], timed_out[d]}), 32'd0);
            chk("dump_addr_run", d, 32'(dump_addr[d]), 32'd0);
            if (k[d] >= P_LEN[d]) halt[d] = (hh[d] >= 0 && k[d] >= P_LEN[d] + hh[d]);
            return;
        end
        chk("cycle_count_frozen", d, cycle_count[d], 32'(ee[d]));
        chk("timed_out", d, 32'(timed_out[d]), 32'(texp[d]));
        case (mph[d])
            0: begin
                chk("mem_req", d, 32'(mem_req[d]), 32'd1);
                chk("mem_addr", d, 32'(mem_addr[d]), 32'(exp_addr(d, widx[d])));
                chk("idle_in_req", d, 32'({dump_valid[d], done[d]}), 32'd0);
                if (stl[d] == 0) begin
                    mem_ack[d] = 1'b1;
                    mem_rdata[d] = mem_word(d, mem_addr[d]);
                    mph[d] = 1;
                    stl[d] = pick(d, 1'b0);
                end else begin
                    stl[d]--;
                    mem_ack[d] = 1'b0;
                end
            end
            1: begin
                chk("dump_valid", d, 32'(dump_valid[d]), 32'd1);
                chk("idle_in_out", d, 32'({mem_req[d], done[d]}), 32'd0);
                chk("dump_addr", d, 32'(dump_addr[d]), 32'(exp_addr(d, widx[d])));
                chk("dump_data", d, dump_data[d], mem_word(d, exp_addr(d, widx[d])));
                chk("dump_last", d, 32'(dump_last[d]), 32'(widx[d] == P_WORDS[d] - 1));
                if (plan[d][run_i[d]].abort == widx[d]) begin
                    begin_reset(d);
                    return;
                end
                if (stl[d] == 0) begin
                    dump_ready[d] = 1'b1;
                    nwords[d]++;
                    if (nwords[d] == 1) first_addr[d] = dump_addr[d];
                    last_addr[d] = dump_addr[d];
                    last_data[d] = dump_data[d];
                    if (widx[d] < 8) cap[d][widx[d]] = dump_addr[d];
                    widx[d]++;
                    mph[d] = (widx[d] == P_WORDS[d]) ? 2 : 0;
                    stl[d] = pick(d, 1'b1);
                end else begin
                    stl[d]--;
                    dump_ready[d] = 1'b0;
                end
            end
            default: begin
                chk("done", d, 32'(done[d]), 32'd1);
                chk("idle_in_done", d, 32'({mem_req[d], dump_valid[d], dump_last[d], core_rst[d]}), 32'd0);
                dcyc[d]++;
                if (dcyc[d] == 3) begin
                    end_checks(d);
                    if (run_i[d] + 1 < nruns[d]) begin
                        begin_reset(d);
                    end else begin
                        fin[d] = 1'b1;
                    end
                end
            end
        endcase
    endtask

    initial begin
        bit all_fin;
        ncmp = 0;
        nerr = 0;
        cyc  = 0;
        plan[0][0] = '{37, 1'b0, NOABORT};
        plan[0][1] = '{NEVER, 1'b1, NOABORT};
        plan[0][2] = '{999, 1'b1, NOABORT};
        plan[0][3] = '{RANDH, 1'b1, NOABORT};
        plan[0][4] = '{5, 1'b1, 10};
        plan[0][5] = '{3, 1'b1, NOABORT};
        plan[1][0] = '{3, 1'b1, NOABORT};
        plan[1][1] = '{NEVER, 1'b1, NOABORT};
        plan[1][2] = '{19, 1'b1, NOABORT};
        plan[1][3] = '{0, 1'b1, NOABORT};
        plan[2][0] = '{4, 1'b0, NOABORT};
        plan[2][1] = '{NEVER, 1'b1, NOABORT};
        nruns = '{6, 4, 2};
        for (int d = 0; d < ND; d++) begin
            rst[d]   = 1'b0;
            rlow[d]  = 5;
            run_i[d] = 0;
            fin[d]   = 1'b0;
            halt[d] = 1'b0;
            mem_ack[d] = 1'b0;
            dump_ready[d] = 1'b0;
            mem_rdata[d] = '0;
        end
        all_fin = 1'b0;
        while (!all_fin && cyc < LIM) begin
            @(negedge clk);
            cyc++;
            for (int d = 0; d < ND; d++) step(d);
            all_fin = fin[0] && fin[1] && fin[2];
        end
        if (!all_fin) begin
            ncmp++;
            nerr++;
            $display("FAIL watchdog: got %0d cycles without completion, want completion under %0d", cyc, LIM);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
